sram_arbiter: RTL

- Shares the single 16-bit external SRAM between instruction fetch (IF) and the data-memory stage (DM) of the 16-bit pipelined CPU.
- Sequences SRAM control strobes for multi-cycle reads and writes.
- DM has fixed priority over IF.
- Drives mem_conflict, which the hazard unit uses to stall the PC/IF stage while DM owns the memory.

---
 rtl/sram_arbiter_pkg.sv | 22 ++
 rtl/sram_arbiter_if.sv | 37 +++
 rtl/sram_access_timer.sv | 26 ++
 rtl/sram_arbiter.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared encodings and defaults for the SRAM arbiter slice.
package sram_arbiter_pkg;

  // Default access length; legal range is 2..15 so it fits the 4-bit timer.
  localparam int ACC_CYCLES_DEF = 2;
  localparam int TIMER_W        = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WR_PULSE = 3'd3,
    ST_WR_HOLD  = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// Bus bundle between the CPU ports (IF/DM), the external SRAM and the arbiter.
// master = CPU plus SRAM side, slave = the arbiter itself.
interface sram_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;
  logic              mem_conflict;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic              sram_wr_en;
  logic [DATA_W-1:0] sram_rdata;
  logic              sram_ce_n;
  logic              sram_oe_n;
  logic              sram_we_n;

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, sram_rdata,
    input  if_rdata, if_ack, dm_rdata, dm_ack, mem_conflict,
           sram_addr, sram_wdata, sram_wr_en, sram_ce_n, sram_oe_n, sram_we_n
  );

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, sram_rdata,
    output if_rdata, if_ack, dm_rdata, dm_ack, mem_conflict,
           sram_addr, sram_wdata, sram_wr_en, sram_ce_n, sram_oe_n, sram_we_n
  );
endinterface

// File: rtl/sram_access_timer.sv
// Loadable down-counter timing the RD and WR_PULSE phases; done when it hits 0.
module sram_access_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);
  logic [W-1:0] count_reg;

  // Load has priority; counting stops at zero so done stays stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (en && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign done = (count_reg == '0);
endmodule

// File: rtl/sram_arbiter.sv
// Shares one external SRAM between instruction fetch and the data-memory stage.
// DM wins arbitration in IDLE; a granted access always runs to completion.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int ACC_CYCLES = ACC_CYCLES_DEF
) (
  input logic           clk,
  input logic           rst,
  sram_arbiter_if.slave bus
);
  // RD lasts ACC_CYCLES cycles and WR_PULSE ACC_CYCLES-1; the timer flags the
  // last cycle on zero, so load one less than each length.
  localparam logic [TIMER_W-1:0] RD_LOAD = TIMER_W'(ACC_CYCLES - 1);
  localparam logic [TIMER_W-1:0] WP_LOAD = TIMER_W'(ACC_CYCLES - 2);

  state_t              state_reg, state_next;
  owner_t              owner_reg, owner_next;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [DATA_W-1:0]   if_rdata_reg, dm_rdata_reg;
  logic                latch_dm, latch_if, cap_rd;
  logic                tmr_load, tmr_en, tmr_done;
  logic [TIMER_W-1:0]  tmr_val;
  logic                ce_n, oe_n, we_n, wr_en, if_ack, dm_ack;

  sram_access_timer #(.W(TIMER_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .done     (tmr_done)
  );

  // State and owner registers; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      owner_reg <= OWN_IF;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
    end
  end

  // Capture address/data at grant so requester changes after grant are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else if (latch_dm) begin
      addr_reg  <= bus.dm_addr;
      wdata_reg <= bus.dm_wdata;
    end else if (latch_if) begin
      addr_reg  <= bus.if_addr;
    end
  end

  // Per-owner read data, updated only when that owner's read completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rdata_reg <= '0;
      dm_rdata_reg <= '0;
    end else if (cap_rd) begin
      if (owner_reg == OWN_DM) begin
        dm_rdata_reg <= bus.sram_rdata;
      end else begin
        if_rdata_reg <= bus.sram_rdata;
      end
    end
  end

  // Next-state, grant decisions and SRAM strobes.
  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    latch_dm   = 1'b0;
    latch_if   = 1'b0;
    cap_rd     = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = RD_LOAD;
    tmr_en     = 1'b0;
    ce_n       = 1'b1;
    oe_n       = 1'b1;
    we_n       = 1'b1;
    wr_en      = 1'b0;
    if_ack     = 1'b0;
    dm_ack     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.dm_req) begin
          owner_next = OWN_DM;
          latch_dm   = 1'b1;
          tmr_load   = 1'b1;
          state_next = bus.dm_we ? ST_WR_SETUP : ST_RD;
        end else if (bus.if_req) begin
          owner_next = OWN_IF;
          latch_if   = 1'b1;
          tmr_load   = 1'b1;
          state_next = ST_RD;
        end
      end
      ST_RD: begin
        ce_n   = 1'b0;
        oe_n   = 1'b0;
        tmr_en = 1'b1;
        if (tmr_done) begin
          cap_rd     = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_WR_SETUP: begin
        ce_n       = 1'b0;
        wr_en      = 1'b1;
        tmr_load   = 1'b1;
        tmr_val    = WP_LOAD;
        state_next = ST_WR_PULSE;
      end
      ST_WR_PULSE: begin
        ce_n   = 1'b0;
        we_n   = 1'b0;
        wr_en  = 1'b1;
        tmr_en = 1'b1;
        if (tmr_done) begin
          state_next = ST_WR_HOLD;
        end
      end
      ST_WR_HOLD: begin
        ce_n       = 1'b0;
        wr_en      = 1'b1;
        state_next = ST_DONE;
      end
      ST_DONE: begin
        if_ack     = (owner_reg == OWN_IF);
        dm_ack     = (owner_reg == OWN_DM);
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.sram_ce_n    = ce_n;
  assign bus.sram_oe_n    = oe_n;
  assign bus.sram_we_n    = we_n;
  assign bus.sram_wr_en   = wr_en;
  assign bus.sram_addr    = addr_reg;
  assign bus.sram_wdata   = wdata_reg;
  assign bus.if_ack       = if_ack;
  assign bus.dm_ack       = dm_ack;
  assign bus.if_rdata     = if_rdata_reg;
  assign bus.dm_rdata     = dm_rdata_reg;
  // IF is blocked whenever DM holds or is about to take the memory.
  assign bus.mem_conflict = bus.if_req &&
                            ((state_reg == ST_IDLE) ? bus.dm_req : (owner_reg == OWN_DM));
endmodule
